mac_iter_sched: RTL and testbench

Iteration scheduler for the MAC engine datapath. It replaces microcode address generation with a fixed job loop. Once configured and started, it runs `nb_iter` iterations; each iteration requests the source streams, starts the engine, and drains the result to the sink. Stream base addresses advance by a programmable stride per iteration. It sits between the control slave register file and the streamer/engine flag and control buses.

---
 rtl/mac_iter_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_mac_iter_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_iter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mac_iter_sched
//  Description : Iteration scheduler for the MAC engine datapath. It runs a
//                fixed job loop of nb_iter iterations. Each iteration requests
//                the source streams, starts the engine, then drains the result
//                to the sink. Stream addresses advance by a latched stride.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_iter_sched #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,

   // job configuration
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  nb_iter_i,
   input  logic [ADDR_WIDTH-1:0] base_a_i,
   input  logic [ADDR_WIDTH-1:0] base_b_i,
   input  logic [ADDR_WIDTH-1:0] base_c_i,
   input  logic [ADDR_WIDTH-1:0] base_d_i,
   input  logic [ADDR_WIDTH-1:0] stride_i,
   input  logic                  simple_mul_i,

   // source streamer
   output logic                  src_req_o,
   input  logic                  src_ready_i,
   output logic [ADDR_WIDTH-1:0] src_addr_a_o,
   output logic [ADDR_WIDTH-1:0] src_addr_b_o,
   output logic [ADDR_WIDTH-1:0] src_addr_c_o,
   output logic                  src_use_c_o,

   // engine
   output logic                  engine_start_o,
   input  logic                  engine_done_i,

   // sink streamer
   output logic                  sink_req_o,
   input  logic                  sink_ready_i,
   output logic [ADDR_WIDTH-1:0] sink_addr_d_o,
   input  logic                  sink_done_i,

   // status
   output logic                  busy_o,
   output logic                  done_o,
   output logic [CNT_WIDTH-1:0]  iter_o
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SRC_REQ   = 3'd1;
   localparam logic [2:0] ST_COMPUTE   = 3'd2;
   localparam logic [2:0] ST_SINK_REQ  = 3'd3;
   localparam logic [2:0] ST_SINK_WAIT = 3'd4;
   localparam logic [2:0] ST_FINISH    = 3'd5;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [2:0]            state;
   logic [2:0]            next_state;

   // High only in the first COMPUTE cycle; doubles as the engine start pulse.
   logic                  first_compute;

   logic [CNT_WIDTH-1:0]  nb_iter;
   logic [CNT_WIDTH-1:0]  iter_cnt;
   logic [ADDR_WIDTH-1:0] stride;
   logic                  use_c;

   logic [ADDR_WIDTH-1:0] addr_a;
   logic [ADDR_WIDTH-1:0] addr_b;
   logic [ADDR_WIDTH-1:0] addr_c;
   logic [ADDR_WIDTH-1:0] addr_d;

   // ------------------------------------------------------------------------
   // Event decode: every handshake is qualified by the state expecting it, so
   // stray pulses in other states are simply never seen.
   // ------------------------------------------------------------------------
   logic job_start;
   logic src_accept;
   logic engine_finish;
   logic sink_accept;
   logic sink_complete;
   logic last_iter;
   logic advance;

   assign job_start     = (state == ST_IDLE)      && start_i;
   assign src_accept    = (state == ST_SRC_REQ)   && src_ready_i;
   // engine_done is not trusted in the cycle the engine is being started
   assign engine_finish = (state == ST_COMPUTE)   && !first_compute && engine_done_i;
   assign sink_accept   = (state == ST_SINK_REQ)  && sink_ready_i;
   assign sink_complete = (state == ST_SINK_WAIT) && sink_done_i;
   // nb_iter is never 0 while in SINK_WAIT, so the subtraction cannot wrap here
   assign last_iter     = (iter_cnt == (nb_iter - CNT_ONE));
   assign advance       = sink_complete && !last_iter;

   // Next-state selection for the job loop
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (start_i) begin
               next_state = (nb_iter_i == '0) ? ST_FINISH : ST_SRC_REQ;
            end
         end
         ST_SRC_REQ: begin
            if (src_accept) begin
               next_state = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            if (engine_finish) begin
               next_state = ST_SINK_REQ;
            end
         end
         ST_SINK_REQ: begin
            if (sink_accept) begin
               next_state = ST_SINK_WAIT;
            end
         end
         ST_SINK_WAIT: begin
            if (sink_complete) begin
               next_state = last_iter ? ST_FINISH : ST_SRC_REQ;
            end
         end
         ST_FINISH: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // State register; soft clear overrides any pending transition
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ST_IDLE;
      end else if (clear_i) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // First-COMPUTE marker, set by the source acceptance that enters COMPUTE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         first_compute <= 1'b0;
      end else if (clear_i) begin
         first_compute <= 1'b0;
      end else begin
         first_compute <= src_accept;
      end
   end

   // Job configuration captured at start so later input changes are harmless
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nb_iter <= '0;
         stride  <= '0;
         use_c   <= 1'b0;
      end else if (clear_i) begin
         nb_iter <= '0;
         stride  <= '0;
         use_c   <= 1'b0;
      end else if (job_start) begin
         nb_iter <= nb_iter_i;
         stride  <= stride_i;
         use_c   <= ~simple_mul_i;
      end
   end

   // Iteration index: cleared at start, bumped on each non-final write-back
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         iter_cnt <= '0;
      end else if (clear_i) begin
         iter_cnt <= '0;
      end else if (job_start) begin
         iter_cnt <= '0;
      end else if (advance) begin
         iter_cnt <= iter_cnt + CNT_ONE;
      end
   end

   // Stream addresses: load bases at start, step by the stride (mod 2^W)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_a <= '0;
         addr_b <= '0;
         addr_c <= '0;
         addr_d <= '0;
      end else if (clear_i) begin
         addr_a <= '0;
         addr_b <= '0;
         addr_c <= '0;
         addr_d <= '0;
      end else if (job_start) begin
         addr_a <= base_a_i;
         addr_b <= base_b_i;
         addr_c <= base_c_i;
         addr_d <= base_d_i;
      end else if (advance) begin
         addr_a <= addr_a + stride;
         addr_b <= addr_b + stride;
         addr_c <= addr_c + stride;
         addr_d <= addr_d + stride;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: pure decodes of registered state, no input-to-output paths
   // ------------------------------------------------------------------------
   assign src_req_o      = (state == ST_SRC_REQ);
   assign sink_req_o     = (state == ST_SINK_REQ);
   assign engine_start_o = first_compute;
   assign busy_o         = (state != ST_IDLE);
   assign done_o         = (state == ST_FINISH);
   assign iter_o         = iter_cnt;
   assign src_addr_a_o   = addr_a;
   assign src_addr_b_o   = addr_b;
   assign src_addr_c_o   = addr_c;
   assign sink_addr_d_o  = addr_d;
   assign src_use_c_o    = use_c;

endmodule
`default_nettype wire

// File: tb/tb_mac_iter_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_iter_sched
//  Description : Self-checking bench for mac_iter_sched. A job-level reference
//                model (phase + iteration index, addresses as base+i*stride)
//                is compared against the DUT every cycle, plus literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_iter_sched;

   localparam int AW = 32;
   localparam int CW = 16;

   logic          clk_i        = 1'b0;
   logic          rst_ni       = 1'b1;
   logic          clear_i      = 1'b0;
   logic          start_i      = 1'b0;
   logic [CW-1:0] nb_iter_i    = '0;
   logic [AW-1:0] base_a_i     = '0;
   logic [AW-1:0] base_b_i     = '0;
   logic [AW-1:0] base_c_i     = '0;
   logic [AW-1:0] base_d_i     = '0;
   logic [AW-1:0] stride_i     = '0;
   logic          simple_mul_i = 1'b0;
   logic          src_ready_i  = 1'b0;
   logic          engine_done_i = 1'b0;
   logic          sink_ready_i = 1'b0;
   logic          sink_done_i  = 1'b0;

   logic          src_req_o;
   logic [AW-1:0] src_addr_a_o;
   logic [AW-1:0] src_addr_b_o;
   logic [AW-1:0] src_addr_c_o;
   logic          src_use_c_o;
   logic          engine_start_o;
   logic          sink_req_o;
   logic [AW-1:0] sink_addr_d_o;
   logic          busy_o;
   logic          done_o;
   logic [CW-1:0] iter_o;

   mac_iter_sched #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .start_i        (start_i),
      .nb_iter_i      (nb_iter_i),
      .base_a_i       (base_a_i),
      .base_b_i       (base_b_i),
      .base_c_i       (base_c_i),
      .base_d_i       (base_d_i),
      .stride_i       (stride_i),
      .simple_mul_i   (simple_mul_i),
      .src_req_o      (src_req_o),
      .src_ready_i    (src_ready_i),
      .src_addr_a_o   (src_addr_a_o),
      .src_addr_b_o   (src_addr_b_o),
      .src_addr_c_o   (src_addr_c_o),
      .src_use_c_o    (src_use_c_o),
      .engine_start_o (engine_start_o),
      .engine_done_i  (engine_done_i),
      .sink_req_o     (sink_req_o),
      .sink_ready_i   (sink_ready_i),
      .sink_addr_d_o  (sink_addr_d_o),
      .sink_done_i    (sink_done_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .iter_o         (iter_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: where the job is, which iteration, latched config.
   // ------------------------------------------------------------------------
   typedef enum int {P_IDLE, P_SRC, P_ENG0, P_ENG, P_SINK, P_WAIT, P_FIN} phase_t;

   phase_t        ph       = P_IDLE;
   int unsigned   m_iter   = 0;
   int unsigned   m_nb     = 0;
   logic [AW-1:0] m_base [4] = '{default: '0};
   logic [AW-1:0] m_stride = '0;
   logic          m_use_c  = 1'b0;

   function automatic logic [AW-1:0] exp_addr(input int k);
      logic [AW-1:0] it;
      it = AW'(m_iter);
      return m_base[k] + m_stride * it;
   endfunction

   initial forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni || clear_i) begin
         ph = P_IDLE; m_iter = 0; m_nb = 0; m_stride = '0; m_use_c = 1'b0;
         for (int k = 0; k < 4; k++) m_base[k] = '0;
      end else begin
         case (ph)
            P_IDLE: if (start_i) begin
               m_nb = nb_iter_i; m_stride = stride_i; m_use_c = ~simple_mul_i;
               m_base[0] = base_a_i; m_base[1] = base_b_i;
               m_base[2] = base_c_i; m_base[3] = base_d_i;
               m_iter = 0;
               ph = (nb_iter_i == 0) ? P_FIN : P_SRC;
            end
            P_SRC:  if (src_ready_i) ph = P_ENG0;
            P_ENG0: ph = P_ENG;
            P_ENG:  if (engine_done_i) ph = P_SINK;
            P_SINK: if (sink_ready_i) ph = P_WAIT;
            P_WAIT: if (sink_done_i) begin
               if (m_iter == m_nb - 1) ph = P_FIN;
               else begin m_iter++; ph = P_SRC; end
            end
            default: ph = P_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Per-cycle compare against the model, plus event bookkeeping
   // ------------------------------------------------------------------------
   int eng_cnt = 0, done_cnt = 0, src_seen = 0, sink_seen = 0, usec_busy = 0, viol = 0;
   int ncyc = 0, src_run = 0, sink_run = 0;
   logic [AW-1:0] acc_a[$];
   logic [AW-1:0] acc_d[$];
   int eng_cyc[$];
   int src_runs[$];
   int sink_runs[$];
   logic p_src = 0, p_src_rdy = 0, p_sink = 0, p_sink_rdy = 0, p_ok = 0;
   logic [AW-1:0] p_a = '0, p_b = '0, p_c = '0, p_d = '0;

   initial forever begin
      @(negedge clk_i);
      ncyc++;
      chk("busy_o",         busy_o,         ph != P_IDLE);
      chk("src_req_o",      src_req_o,      ph == P_SRC);
      chk("engine_start_o", engine_start_o, ph == P_ENG0);
      chk("sink_req_o",     sink_req_o,     ph == P_SINK);
      chk("done_o",         done_o,         ph == P_FIN);
      chk("iter_o",         iter_o,         m_iter);
      chk("src_addr_a_o",   src_addr_a_o,   exp_addr(0));
      chk("src_addr_b_o",   src_addr_b_o,   exp_addr(1));
      chk("src_addr_c_o",   src_addr_c_o,   exp_addr(2));
      chk("sink_addr_d_o",  sink_addr_d_o,  exp_addr(3));
      chk("src_use_c_o",    src_use_c_o,    m_use_c);

      if (engine_start_o) begin eng_cnt++; eng_cyc.push_back(ncyc); end
      if (done_o) done_cnt++;
      if (src_req_o) src_seen++;
      if (sink_req_o) sink_seen++;
      if (busy_o && src_use_c_o) usec_busy++;
      if (src_req_o && src_ready_i) acc_a.push_back(src_addr_a_o);
      if (sink_req_o && sink_ready_i) acc_d.push_back(sink_addr_d_o);

      // a pending, unaccepted request must persist with unchanged addresses
      if (p_ok && rst_ni && p_src && !p_src_rdy &&
          (!src_req_o || src_addr_a_o != p_a || src_addr_b_o != p_b || src_addr_c_o != p_c))
         viol++;
      if (p_ok && rst_ni && p_sink && !p_sink_rdy && (!sink_req_o || sink_addr_d_o != p_d))
         viol++;

      if (src_req_o) src_run++;
      else if (src_run != 0) begin src_runs.push_back(src_run); src_run = 0; end
      if (sink_req_o) sink_run++;
      else if (sink_run != 0) begin sink_runs.push_back(sink_run); sink_run = 0; end

      p_src = src_req_o; p_src_rdy = src_ready_i; p_sink = sink_req_o; p_sink_rdy = sink_ready_i;
      p_a = src_addr_a_o; p_b = src_addr_b_o; p_c = src_addr_c_o; p_d = sink_addr_d_o;
      p_ok = rst_ni && !clear_i;
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_job(input int nb, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            input logic [AW-1:0] c, input logic [AW-1:0] d,
                            input logic [AW-1:0] s, input bit sm);
      nb_iter_i = CW'(nb); base_a_i = a; base_b_i = b; base_c_i = c; base_d_i = d;
      stride_i = s; simple_mul_i = sm; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      // configuration inputs may wander during the job
      nb_iter_i = CW'($urandom); base_a_i = $urandom; base_b_i = $urandom;
      base_c_i = $urandom; base_d_i = $urandom; stride_i = $urandom;
      simple_mul_i = 1'($urandom);
   endtask

   // Streamer/engine responder with programmable latencies. Returns on done_o,
   // or on the stop_eng-th engine start when stop_eng is non-zero.
   task automatic serve(input int sd, input int kd, input int ed, input int dd,
                        input bit noise, input bit stray, input int stop_eng, output bit ok);
      int ws, ks, ec, dc, neng;
      bit pe, psd;
      ws = 0; ks = 0; ec = 0; dc = 0; neng = 0; pe = 0; psd = 0; ok = 0;
      for (int c = 0; c < 3000; c++) begin
         if (done_o) begin ok = 1; break; end
         if (engine_start_o) begin
            neng++;
            if (stop_eng != 0 && neng == stop_eng) begin ok = 1; break; end
         end
         sink_done_i = 1'b0;
         if (psd) begin
            if (dc >= dd) begin sink_done_i = 1'b1; psd = 0; end
            else dc++;
         end
         if (src_req_o) begin src_ready_i = (ws >= sd); ws++; end
         else begin src_ready_i = 1'b0; ws = 0; end
         if (engine_start_o) begin pe = 1; ec = 0; end
         if (sink_req_o) pe = 0;
         engine_done_i = pe && ec >= ed && ec >= 1;
         if (pe) ec++;
         if (sink_req_o) begin
            sink_ready_i = (ks >= kd);
            if (sink_ready_i) begin psd = 1; dc = 0; end
            ks++;
         end else begin
            sink_ready_i = 1'b0; ks = 0;
         end
         if (stray) begin
            if (src_req_o || engine_start_o) engine_done_i = 1'b1;
            if (busy_o) start_i = 1'b1;
         end
         if (noise) begin
            if (!src_req_o && $urandom_range(3) == 0) src_ready_i = 1'b1;
            if ($urandom_range(3) == 0) engine_done_i = 1'b1;
            if (!sink_req_o && $urandom_range(3) == 0) sink_ready_i = 1'b1;
            if (!psd && $urandom_range(5) == 0) sink_done_i = 1'b1;
            start_i = ($urandom_range(4) == 0);
            base_a_i = $urandom; stride_i = $urandom; nb_iter_i = CW'($urandom);
            simple_mul_i = 1'($urandom);
         end
         tick();
      end
      src_ready_i = 1'b0; engine_done_i = 1'b0; sink_ready_i = 1'b0;
      sink_done_i = 1'b0; start_i = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Test sequence
   // ------------------------------------------------------------------------
   initial begin
      bit ok;
      int e0, d0, s0, k0, r0, q0, u0, v0, qa, qe, qd;
      logic [AW-1:0] exp_a [3];
      exp_a[0] = 32'h1000; exp_a[1] = 32'h1040; exp_a[2] = 32'h1080;

      #1 rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      chk("reset busy_o", busy_o, 0);
      chk("reset done_o", done_o, 0);
      chk("reset src_req_o", src_req_o, 0);
      chk("reset sink_addr_d_o", sink_addr_d_o, 0);
      chk("reset iter_o", iter_o, 0);
      tick();

      // basic job with immediate handshakes
      e0 = eng_cnt; d0 = done_cnt; qa = acc_a.size(); qe = eng_cyc.size();
      start_job(3, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h40, 1'b0);
      serve(0, 0, 0, 0, 0, 0, 0, ok);
      chk("basic job completes", ok, 1);
      chk("basic final iter_o", iter_o, 2);
      chk("basic src_use_c_o", src_use_c_o, 1);
      tick();
      chk("basic engine starts", eng_cnt - e0, 3);
      chk("basic done pulses", done_cnt - d0, 1);
      chk("basic src accepts", acc_a.size() - qa, 3);
      if (acc_a.size() - qa == 3)
         for (int i = 0; i < 3; i++) chk("basic src_addr_a sequence", acc_a[qa + i], exp_a[i]);
      if (eng_cyc.size() - qe >= 2)
         chk("basic iteration length", eng_cyc[qe + 1] - eng_cyc[qe], 5);

      // empty job
      e0 = eng_cnt; d0 = done_cnt; s0 = src_seen; k0 = sink_seen;
      nb_iter_i = '0; start_i = 1'b1;
      @(negedge clk_i);
      chk("empty done_o before sampling edge", done_o, 0);
      @(posedge clk_i);
      #1 start_i = 1'b0;
      @(negedge clk_i);
      chk("empty done_o at start+2", done_o, 1);
      @(negedge clk_i);
      chk("empty busy_o after done", busy_o, 0);
      tick();
      chk("empty src_req count", src_seen - s0, 0);
      chk("empty sink_req count", sink_seen - k0, 0);
      chk("empty engine starts", eng_cnt - e0, 0);
      chk("empty done pulses", done_cnt - d0, 1);

      // backpressure
      e0 = eng_cnt; r0 = src_runs.size(); q0 = sink_runs.size(); v0 = viol;
      start_job(2, 32'h100, 32'h200, 32'h300, 32'h400, 32'h10, 1'b0);
      serve(7, 4, 3, 2, 0, 0, 0, ok);
      chk("backpressure job completes", ok, 1);
      tick();
      chk("backpressure engine starts", eng_cnt - e0, 2);
      chk("backpressure hold violations", viol - v0, 0);
      chk("backpressure src run count", src_runs.size() - r0, 2);
      chk("backpressure sink run count", sink_runs.size() - q0, 2);
      if (src_runs.size() > r0) chk("backpressure src_req length", src_runs[r0], 8);
      if (sink_runs.size() > q0) chk("backpressure sink_req length", sink_runs[q0], 5);

      // address wrap-around
      qd = acc_d.size();
      start_job(2, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20, 1'b0);
      serve(0, 0, 1, 0, 0, 0, 0, ok);
      chk("wrap job completes", ok, 1);
      tick();
      chk("wrap sink accepts", acc_d.size() - qd, 2);
      if (acc_d.size() - qd == 2) begin
         chk("wrap sink_addr_d first", acc_d[qd], 32'hFFFF_FFF0);
         chk("wrap sink_addr_d second", acc_d[qd + 1], 32'h0000_0010);
      end

      // abort in COMPUTE of iteration 1, then a clean job
      d0 = done_cnt;
      start_job(3, 32'h5000, 32'h6000, 32'h7000, 32'h8000, 32'h100, 1'b0);
      serve(0, 0, 0, 0, 0, 0, 2, ok);
      chk("abort reached iteration 1", ok, 1);
      chk("abort iter_o before clear", iter_o, 1);
      chk("abort src_addr_a before clear", src_addr_a_o, 32'h5100);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      @(negedge clk_i);
      chk("abort busy_o", busy_o, 0);
      chk("abort iter_o", iter_o, 0);
      chk("abort src_addr_a_o", src_addr_a_o, 0);
      chk("abort sink_addr_d_o", sink_addr_d_o, 0);
      chk("abort engine_start_o", engine_start_o, 0);
      repeat (4) tick();
      chk("abort no done pulse", done_cnt - d0, 0);
      qa = acc_a.size();
      start_job(1, 32'h10, 32'h20, 32'h30, 32'h40, 32'h8, 1'b1);
      serve(0, 0, 0, 0, 0, 0, 0, ok);
      chk("post-abort job completes", ok, 1);
      tick();
      chk("post-abort done pulses", done_cnt - d0, 1);
      if (acc_a.size() > qa) chk("post-abort src_addr_a", acc_a[qa], 32'h10);

      // stray inputs with simple_mul
      e0 = eng_cnt; u0 = usec_busy;
      start_job(3, 32'hA000, 32'hB000, 32'hC000, 32'hD000, 32'h4, 1'b1);
      serve(1, 1, 2, 1, 0, 1, 0, ok);
      chk("stray job completes", ok, 1);
      tick();
      chk("stray engine starts", eng_cnt - e0, 3);
      chk("stray src_use_c_o while busy", usec_busy - u0, 0);

      // randomized jobs with noisy handshakes
      for (int j = 0; j < 25; j++) begin
         start_job($urandom_range(0, 4), $urandom, $urandom, $urandom, $urandom, $urandom,
                   1'($urandom));
         serve($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), 1, 0, 0, ok);
         chk("random job completes", ok, 1);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d",
               n_checks, n_errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
